// File: rtl/sfp_vec3_normalize.sv
// rtl/sfp_vec3_normalize.sv - Q16.16 vec3 normalizer (iterative sqrt + restoring divide)
//
// Purpose: turns a raw signed Q16.16 vector (typically a cross product) into a
// unit vector. The flow is sum of squares (1 cycle), then a bit-serial integer
// sqrt (33 cycles), then three restoring divides (17 cycles each).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready is high only in IDLE
//   in_vec[2:0]           signed Q16.16 components, [0]=x [1]=y [2]=z
//   out_valid/out_ready   output handshake; the result is held until accepted
//   out_vec[2:0]          signed Q16.16 unit vector, [0]=x [1]=y [2]=z
//   out_zero              the input was the zero vector (out_vec is zero)
module sfp_vec3_normalize #(
  parameter int IW = 16,
  parameter int QW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0][IW+QW-1:0] in_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0][IW+QW-1:0] out_vec,
  output logic                out_zero
);

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_SQRT, S_DIV, S_OUT} state_t;

  state_t state, state_n;

  logic [2:0][31:0] vec_q;     // latched input vector
  logic [65:0]      rad;       // sqrt radicand, consumed two bits per cycle
  logic [34:0]      sq_rem;    // sqrt partial remainder
  logic [32:0]      root;      // sqrt result; becomes the divisor L
  logic [5:0]       cnt;       // step counter within SQRT / within one component
  logic [1:0]       comp;      // component being divided: 0=x 1=y 2=z
  logic [32:0]      drem;      // divide partial remainder
  logic [QW:0]      dshift;    // remaining low dividend bits, MSB first
  logic [QW-1:0]    quo;       // quotient bits gathered so far
  logic [31:0]      res_x, res_y;

  // Sum of squares: sign-extended operands make the low 64 product bits the
  // exact signed square (at most 2^62), so the sum fits comfortably in 66 b.
  logic [63:0] sx, sy, sz, px, py, pz;
  logic [65:0] sq_sum;

  always_comb begin
    sx = {{32{vec_q[0][31]}}, vec_q[0]};
    sy = {{32{vec_q[1][31]}}, vec_q[1]};
    sz = {{32{vec_q[2][31]}}, vec_q[2]};
    px = sx * sx;
    py = sy * sy;
    pz = sz * sz;
    sq_sum = {2'b00, px} + {2'b00, py} + {2'b00, pz};
  end

  // One sqrt step: bring down two radicand bits, try subtracting 4*root+1.
  // The remainder's top bits act as a carry so the compare never overflows.
  logic [34:0] rs, trial;
  logic        sge;

  always_comb begin
    rs    = {sq_rem[32:0], rad[65:64]};
    trial = {root, 2'b01};
    sge   = (|sq_rem[34:33]) || (rs >= trial);
  end

  // One restoring-divide step against L; the bit shifted out of drem is the
  // carry that forces a subtract when the shifted remainder exceeds 33 b.
  logic [32:0] dt;
  logic        dge;

  always_comb begin
    dt  = {drem[31:0], dshift[QW]};
    dge = drem[32] || (dt >= root);
  end

  // Magnitude of the next component to load into the divider. The dividend
  // |c|<<16 is split as: initial remainder |c|>>1, then 17 bits {|c|[0],0..0}.
  // Since |c| <= L, the initial remainder is already below the divisor.
  logic [1:0]  ld_idx;
  logic [31:0] ld_c, ld_mag;

  always_comb begin
    ld_idx = 2'd0;
    if (state == S_DIV && comp != 2'd2) ld_idx = comp + 2'd1;
    ld_c   = vec_q[ld_idx];
    ld_mag = ld_c[31] ? (~ld_c + 32'd1) : ld_c;
  end

  // Final quotient of the current component, truncated toward zero and given
  // the sign of the component.
  logic [31:0] cur_c, q_ext, q_signed;

  always_comb begin
    cur_c    = vec_q[comp];
    q_ext    = {15'd0, quo, dge};
    q_signed = cur_c[31] ? (~q_ext + 32'd1) : q_ext;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_SQ;
      end
      S_SQ:   state_n = (sq_sum == 66'd0) ? S_OUT : S_SQRT;
      S_SQRT: if (cnt == 6'd32) state_n = S_DIV;
      S_DIV:  if (cnt == 6'(QW) && comp == 2'd2) state_n = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      vec_q    <= '0;
      rad      <= '0;
      sq_rem   <= '0;
      root     <= '0;
      cnt      <= '0;
      comp     <= '0;
      drem     <= '0;
      dshift   <= '0;
      quo      <= '0;
      res_x    <= '0;
      res_y    <= '0;
      out_vec  <= '0;
      out_zero <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (in_valid) vec_q <= in_vec;
        S_SQ: begin
          rad    <= sq_sum;
          sq_rem <= '0;
          root   <= '0;
          cnt    <= '0;
          if (sq_sum == 66'd0) begin
            out_vec  <= '0;
            out_zero <= 1'b1;
          end
        end
        S_SQRT: begin
          sq_rem <= sge ? (rs - trial) : rs;
          root   <= {root[31:0], sge};
          rad    <= {rad[63:0], 2'b00};
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd32) begin
            cnt    <= '0;
            comp   <= 2'd0;
            drem   <= {2'b00, ld_mag[31:1]};
            dshift <= {ld_mag[0], {QW{1'b0}}};
            quo    <= '0;
          end
        end
        S_DIV: begin
          drem   <= dge ? (dt - root) : dt;
          dshift <= {dshift[QW-1:0], 1'b0};
          quo    <= {quo[QW-2:0], dge};
          cnt    <= cnt + 6'd1;
          if (cnt == 6'(QW)) begin
            cnt    <= '0;
            comp   <= (comp == 2'd2) ? 2'd0 : comp + 2'd1;
            drem   <= {2'b00, ld_mag[31:1]};
            dshift <= {ld_mag[0], {QW{1'b0}}};
            quo    <= '0;
            case (comp)
              2'd0: res_x <= q_signed;
              2'd1: res_y <= q_signed;
              default: begin
                out_vec  <= {q_signed, res_y, res_x};
                out_zero <= 1'b0;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sfp_vec3_normalize.md
Name: sfp_vec3_normalize

Overview:
Sequential Q16.16 signed fixed-point vec3 normalizer. It sits directly downstream of the combinational vec3 cross-product stage and turns raw cross products (surface/triangle normals) into unit vectors for the shading and intersection pipeline. It uses an iterative integer square root and a restoring divider controlled by an FSM, with valid/ready handshakes on both sides.

Parameters:
IW, 16, integer bits of input/output format (fixed, matches sfp_if IW=16)
QW, 16, fraction bits of input/output format (fixed, matches sfp_if QW=16)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector
in_vec  input  32 x [3]  signed Q16.16 components x,y,z
out_valid  output  1  result valid, held until accepted
out_ready  input  1  downstream accepts result
out_vec  output  32 x [3]  signed Q16.16 unit vector
out_zero  output  1  input was the zero vector; out_vec is all zero

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_vec={0,0,0}, out_zero=0. rst overrides any in-flight operation; a vector in progress is discarded with no output.
- States: IDLE, SQ, SQRT, DIV, OUT. in_ready = (state==IDLE). No accept while busy or in OUT.
- IDLE: on in_valid&&in_ready, latch in_vec and go to SQ (this is edge 0).
- SQ (1 cycle): sq = x*x + y*y + z*z. Full-precision signed products (64 b), unsigned sum in 66 b, Q32.32. If sq==0, go to OUT with out_vec=0 and out_zero=1. Otherwise go to SQRT.
- SQRT (33 cycles): bit-serial floor integer sqrt of sq, one result bit per cycle, MSB first. L = floor(sqrt(sq)), 33 b unsigned, Q17.16 (a Q32.32 root is Q16.16 raw). L>=1 is guaranteed here.
- DIV (51 cycles = 3 x 17): components are processed in order x, y, z. Each uses a restoring divide of |c|<<16 (48 b) by L, 17 quotient bits MSB first, truncated toward zero. The result takes the sign of c (two's-complement negate if c<0). |c|<=L, so |q|<=0x00010000 and no saturation is needed. Go to OUT after z.
- OUT: out_valid=1. out_vec/out_zero are stable until out_valid&&out_ready, then return to IDLE. in_ready rises on the following cycle (no same-cycle re-accept). out_zero clears with the next accepted vector's result.
- Latency, non-zero vector: out_valid rises after edge 85 from the accepting edge (1+33+51). Zero vector: out_valid rises after edge 1.
- out_valid must never drop without a handshake. out_vec may only change in SQ→OUT or DIV→OUT transitions or on reset.
- Most-negative input 0x80000000 is legal: its square is 2^62 and its magnitude 2^31 fits the 48-b dividend.

Test Plan:
- Reset, then in_vec=(0x00030000,0x00040000,0) with out_ready=1 -> after 85 edges, out_vec=(0x00009999,0x0000CCCC,0x00000000), out_zero=0; in_ready low throughout the operation.
- in_vec=(0xFFFD0000,0,0x00040000) -> out_vec=(0xFFFF6667,0x00000000,0x0000CCCC).
- in_vec=(0,0,0) -> out_valid after 1 edge, out_vec=(0,0,0), out_zero=1. Next input (0x00010000,0,0) -> out_vec=(0x00010000,0,0), out_zero=0.
- in_vec=(0x7FFFFFFF,0x7FFFFFFF,0x7FFFFFFF) -> L raw=3719550785, out_vec=(0x000093CD,0x000093CD,0x000093CD).
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_vec stable and in_ready=0 while in_valid=1. Raise out_ready -> one handshake, then in_ready=1 the next cycle.
- Assert rst during SQRT and during DIV -> next cycle out_valid=0, in_ready=1, outputs zero. A following vector (0x00030000,0x00040000,0) produces the correct result with full latency.
